sr_quad_serializer: RTL and testbench

- Receiving end of the upsampler's 4-pixel output protocol.
- Accepts one 2x2 high-res pixel group per handshake and re-serializes it into a raster-order, one-pixel-per-beat stream for the 4K output path.
- The top pair of each group is emitted immediately. The bottom pair is stored in a line buffer and replayed as the following high-res line.

---
 rtl/sr_pkg.sv | 26 ++
 rtl/sr_quad_serializer_if.sv | 30 +++
 rtl/sr_line_buf.sv | 45 ++++
 rtl/sr_quad_serializer.sv | 201 ++++++++++++++++++++
 tb/tb_sr_quad_serializer.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/sr_pkg.sv
// sr_pkg: shared constants, quad field indices and FSM encoding
// for the quad-to-raster serializer.
`default_nettype none

package sr_pkg;

  localparam int PIXEL_WIDTH_DEFAULT = 24;

  // Pixel slot index inside a quad word; slot n occupies [n*PW +: PW].
  localparam int QUAD_TL = 3;
  localparam int QUAD_TR = 2;
  localparam int QUAD_BL = 1;
  localparam int QUAD_BR = 0;

  typedef enum logic [0:0] {
    ST_TOP = 1'b0,
    ST_BOT = 1'b1
  } sr_state_e;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sr_quad_serializer_if.sv
// sr_quad_serializer_if: quad input handshake plus serialized pixel output.
// master = source/sink side (bench), slave = serializer.
`default_nettype none

interface sr_quad_serializer_if #(
  parameter int PIXEL_WIDTH = sr_pkg::PIXEL_WIDTH_DEFAULT
) ();

  logic [4*PIXEL_WIDTH-1:0] quad_in;
  logic                     qin_en;
  logic                     busy;
  logic [PIXEL_WIDTH-1:0]   pixel_out;
  logic                     pout_en;
  logic                     pout_sof;
  logic                     pout_eol;
  logic                     stuck;

  modport master (
    output quad_in, qin_en, stuck,
    input  busy, pixel_out, pout_en, pout_sof, pout_eol
  );

  modport slave (
    input  quad_in, qin_en, stuck,
    output busy, pixel_out, pout_en, pout_sof, pout_eol
  );

endinterface

`default_nettype wire

// File: rtl/sr_line_buf.sv
// sr_line_buf: two-bank simple dual-port line buffer; one shared write
// address for both banks, one registered read port.
`default_nettype none

module sr_line_buf
  import sr_pkg::*;
#(
  parameter int PIXEL_WIDTH = PIXEL_WIDTH_DEFAULT,
  parameter int DEPTH       = 1920,
  parameter int AW          = 11
) (
  input  wire logic                   clk,
  input  wire logic                   we_i,
  input  wire logic [AW-1:0]          waddr_i,
  input  wire logic [PIXEL_WIDTH-1:0] wdata0_i,
  input  wire logic [PIXEL_WIDTH-1:0] wdata1_i,
  input  wire logic                   re_i,
  input  wire logic [AW-1:0]          raddr_i,
  output logic      [PIXEL_WIDTH-1:0] rdata0_o,
  output logic      [PIXEL_WIDTH-1:0] rdata1_o
);

  logic [PIXEL_WIDTH-1:0] bank0_q [DEPTH];
  logic [PIXEL_WIDTH-1:0] bank1_q [DEPTH];
  logic [PIXEL_WIDTH-1:0] rdata0_q;
  logic [PIXEL_WIDTH-1:0] rdata1_q;

  // No reset: contents and read register map onto block RAM primitives.
  always_ff @(posedge clk) begin
    if (we_i) begin
      bank0_q[waddr_i] <= wdata0_i;
      bank1_q[waddr_i] <= wdata1_i;
    end
    if (re_i) begin
      rdata0_q <= bank0_q[raddr_i];
      rdata1_q <= bank1_q[raddr_i];
    end
  end

  assign rdata0_o = rdata0_q;
  assign rdata1_o = rdata1_q;

endmodule

`default_nettype wire

// File: rtl/sr_quad_serializer.sv
// sr_quad_serializer: turns 2x2 pixel groups into a raster pixel stream,
// emitting top pairs live and replaying bottom pairs from a line buffer.
`default_nettype none

module sr_quad_serializer
  import sr_pkg::*;
#(
  parameter int PIXEL_WIDTH = PIXEL_WIDTH_DEFAULT,
  parameter int LR_WIDTH    = 1920,
  parameter int LR_HEIGHT   = 1080
) (
  input wire logic              clk,
  input wire logic              rst_n,
  sr_quad_serializer_if.slave   bus
);

  localparam int XW = cnt_width(LR_WIDTH);
  localparam int YW = cnt_width(LR_HEIGHT);
  localparam int PW = PIXEL_WIDTH;

  sr_state_e        state_q, state_d;
  logic [XW-1:0]    x_q, x_d;
  logic [XW-1:0]    r_q, r_d;
  logic [YW-1:0]    y_q, y_d;
  logic             half_q, half_d;
  logic             last_q, last_d;
  logic [PW-1:0]    hold_q, hold_d;
  logic [PW-1:0]    pix_q, pix_d;
  logic             en_q, en_d;
  logic             sof_q, sof_d;
  logic             eol_q, eol_d;
  logic             sel_q, sel_d;
  logic             vld_q, vld_d;
  logic             rd_done_q, rd_done_d;
  logic             dlast_q, dlast_d;
  logic             fin_q, fin_d;

  logic             w_busy, w_in_xfer, w_out_xfer, w_slot_free, w_load;
  logic             w_we, w_re;
  logic [PW-1:0]    w_rd0, w_rd1;

  assign w_out_xfer  = en_q & ~bus.stuck;
  assign w_slot_free = ~en_q | ~bus.stuck;
  assign w_busy      = (state_q != ST_TOP) | half_q | (en_q & bus.stuck);
  assign w_in_xfer   = bus.qin_en & ~w_busy;
  assign w_load      = (state_q == ST_BOT) & w_slot_free & vld_q;

  sr_line_buf #(
    .PIXEL_WIDTH (PW),
    .DEPTH       (LR_WIDTH),
    .AW          (XW)
  ) u_line_buf (
    .clk      (clk),
    .we_i     (w_we),
    .waddr_i  (x_q),
    .wdata0_i (bus.quad_in[QUAD_BL*PW +: PW]),
    .wdata1_i (bus.quad_in[QUAD_BR*PW +: PW]),
    .re_i     (w_re),
    .raddr_i  (r_q),
    .rdata0_o (w_rd0),
    .rdata1_o (w_rd1)
  );

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    r_d       = r_q;
    y_d       = y_q;
    half_d    = half_q;
    last_d    = last_q;
    hold_d    = hold_q;
    pix_d     = pix_q;
    en_d      = en_q;
    sof_d     = sof_q;
    eol_d     = eol_q;
    sel_d     = sel_q;
    vld_d     = vld_q;
    rd_done_d = rd_done_q;
    dlast_d   = dlast_q;
    fin_d     = fin_q;
    w_we      = 1'b0;
    w_re      = 1'b0;

    unique case (state_q)
      ST_TOP: begin
        if (half_q) begin
          // Switching to BOT as the final top-right loads keeps busy high
          // while that pixel is still on the output.
          if (w_out_xfer) begin
            pix_d  = hold_q;
            sof_d  = 1'b0;
            eol_d  = last_q;
            half_d = 1'b0;
            if (last_q) state_d = ST_BOT;
          end
        end else if (w_in_xfer) begin
          pix_d  = bus.quad_in[QUAD_TL*PW +: PW];
          hold_d = bus.quad_in[QUAD_TR*PW +: PW];
          en_d   = 1'b1;
          sof_d  = (x_q == '0) && (y_q == '0);
          eol_d  = 1'b0;
          half_d = 1'b1;
          w_we   = 1'b1;
          last_d = (x_q == XW'(LR_WIDTH - 1));
          x_d    = (x_q == XW'(LR_WIDTH - 1)) ? '0 : x_q + XW'(1);
        end else if (w_out_xfer) begin
          en_d  = 1'b0;
          sof_d = 1'b0;
          eol_d = 1'b0;
        end
      end

      ST_BOT: begin
        // Fetch the next address as soon as the held pair is exhausted.
        w_re = ~rd_done_q & (~vld_q | (w_load & sel_q));
        if (w_re) begin
          vld_d     = 1'b1;
          dlast_d   = (r_q == XW'(LR_WIDTH - 1));
          rd_done_d = (r_q == XW'(LR_WIDTH - 1));
          r_d       = (r_q == XW'(LR_WIDTH - 1)) ? '0 : r_q + XW'(1);
        end else if (w_load & sel_q) begin
          vld_d = 1'b0;
        end

        if (w_load) begin
          pix_d = sel_q ? w_rd1 : w_rd0;
          en_d  = 1'b1;
          sof_d = 1'b0;
          eol_d = sel_q & dlast_q;
          fin_d = sel_q & dlast_q;
          sel_d = ~sel_q;
        end else if (w_slot_free) begin
          en_d  = 1'b0;
          sof_d = 1'b0;
          eol_d = 1'b0;
        end

        if (fin_q & w_out_xfer) begin
          state_d   = ST_TOP;
          fin_d     = 1'b0;
          rd_done_d = 1'b0;
          vld_d     = 1'b0;
          sel_d     = 1'b0;
          r_d       = '0;
          y_d       = (y_q == YW'(LR_HEIGHT - 1)) ? '0 : y_q + YW'(1);
        end
      end

      default: state_d = ST_TOP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_TOP;
      x_q       <= '0;
      r_q       <= '0;
      y_q       <= '0;
      half_q    <= 1'b0;
      last_q    <= 1'b0;
      pix_q     <= '0;
      en_q      <= 1'b0;
      sof_q     <= 1'b0;
      eol_q     <= 1'b0;
      sel_q     <= 1'b0;
      vld_q     <= 1'b0;
      rd_done_q <= 1'b0;
      dlast_q   <= 1'b0;
      fin_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      r_q       <= r_d;
      y_q       <= y_d;
      half_q    <= half_d;
      last_q    <= last_d;
      pix_q     <= pix_d;
      en_q      <= en_d;
      sof_q     <= sof_d;
      eol_q     <= eol_d;
      sel_q     <= sel_d;
      vld_q     <= vld_d;
      rd_done_q <= rd_done_d;
      dlast_q   <= dlast_d;
      fin_q     <= fin_d;
    end
  end

  always_ff @(posedge clk) begin
    hold_q <= hold_d;
  end

  assign bus.busy      = w_busy;
  assign bus.pixel_out = pix_q;
  assign bus.pout_en   = en_q;
  assign bus.pout_sof  = sof_q;
  assign bus.pout_eol  = eol_q;

endmodule

`default_nettype wire

// File: tb/tb_sr_quad_serializer.sv
// tb_sr_quad_serializer: directed stimulus with a raster scoreboard for
// the quad serializer (LR 4x2, 8-bit pixels).
`default_nettype none

module tb_sr_quad_serializer;

  localparam int PW = 8;
  localparam int W  = 4;
  localparam int H  = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sr_quad_serializer_if #(.PIXEL_WIDTH(PW)) bus ();

  sr_quad_serializer #(
    .PIXEL_WIDTH (PW),
    .LR_WIDTH    (W),
    .LR_HEIGHT   (H)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int n_cmp = 0;
  int n_err = 0;
  int gk    = 0;
  int sof_seen = 0;

  logic [9:0] exp_q[$];   // {sof, eol, pixel}
  logic [9:0] bot_q[$];
  int         mx = 0;
  int         my = 0;
  logic       stall_v = 1'b0;
  logic [9:0] stall_val;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [4*PW-1:0] grp(input int k);
    logic [3:0] kk;
    kk = 4'(k);
    return {kk, 4'h0, kk, 4'h1, kk, 4'h2, kk, 4'h3};
  endfunction

  // Scoreboard: model pushes at input transfer, pops at output transfer.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      bot_q.delete();
      mx = 0;
      my = 0;
      stall_v = 1'b0;
    end else begin
      if (stall_v)
        check("stall_stable", {22'd0, bus.pout_sof, bus.pout_eol, bus.pixel_out},
              {22'd0, stall_val});
      if (bus.pout_en && !bus.stuck) begin
        if (bus.pout_sof) sof_seen++;
        n_cmp++;
        assert (exp_q.size() > 0) else begin
          n_err++;
          $error("FAIL sb_underflow: observed pixel=%0h expected=none", bus.pixel_out);
        end
        if (exp_q.size() > 0)
          check("sb_pixel", {22'd0, bus.pout_sof, bus.pout_eol, bus.pixel_out},
                {22'd0, exp_q.pop_front()});
      end
      if (bus.qin_en && !bus.busy) begin
        exp_q.push_back({(mx == 0 && my == 0), 1'b0, bus.quad_in[31:24]});
        exp_q.push_back({1'b0, (mx == W-1), bus.quad_in[23:16]});
        bot_q.push_back({1'b0, 1'b0, bus.quad_in[15:8]});
        bot_q.push_back({1'b0, (mx == W-1), bus.quad_in[7:0]});
        mx++;
        if (mx == W) begin
          foreach (bot_q[i]) exp_q.push_back(bot_q[i]);
          bot_q.delete();
          mx = 0;
          my = (my == H-1) ? 0 : my + 1;
        end
      end
      stall_v   = bus.pout_en && bus.stuck;
      stall_val = {bus.pout_sof, bus.pout_eol, bus.pixel_out};
    end
  end

  task automatic run_groups(input int n, input bit rnd, input int budget);
    int acc = 0;
    int cyc = 0;
    while (acc < n && cyc < budget) begin
      @(posedge clk); #1;
      bus.quad_in = grp(gk);
      bus.qin_en  = 1'b1;
      bus.stuck   = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge clk);
      if (!bus.busy) begin
        gk++;
        acc++;
      end
      cyc++;
    end
    check("run_accept", acc, n);
  endtask

  task automatic drain(input int budget);
    int cyc = 0;
    bit done = 1'b0;
    while (!done && cyc < budget) begin
      @(posedge clk); #1;
      bus.qin_en = 1'b0;
      bus.stuck  = 1'($urandom_range(0, 1));
      @(negedge clk);
      done = (exp_q.size() == 0) && !bus.pout_en;
      cyc++;
    end
    check("drain_done", done, 1);
    @(posedge clk); #1;
    bus.stuck = 1'b0;
  endtask

  initial begin
    int acc;
    int bubbles;
    logic [4*PW-1:0] a_val;

    rst_n       = 1'b0;
    bus.quad_in = '0;
    bus.qin_en  = 1'b0;
    bus.stuck   = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_pout_en", bus.pout_en, 0);
    check("rst_sof_eol", {bus.pout_sof, bus.pout_eol}, 0);
    check("rst_pixel", bus.pixel_out, 0);
    check("rst_busy", bus.busy, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Continuous offer, no stall: busy pattern and per-line acceptance.
    acc = 0;
    bubbles = 0;
    for (int i = 0; i < 18; i++) begin
      @(posedge clk); #1;
      bus.quad_in = grp(gk);
      bus.qin_en  = 1'b1;
      bus.stuck   = 1'b0;
      @(negedge clk);
      check($sformatf("busy_pat_%0d", i), bus.busy, (i < 8) ? (i % 2) : 1);
      if (i >= 8 && !bus.pout_en) bubbles++;
      if (!bus.busy) begin
        gk++;
        acc++;
      end
    end
    check("groups_per_line", acc, W);
    check("bot_bubbles_le1", (bubbles <= 1), 1);

    // Random 50% stall: rest of frame 1 and all of frame 2.
    run_groups(W + 2*W, 1'b1, 400);
    drain(200);
    check("sof_two_frames", sof_seen, 2);

    // Stall on the top-right while a new group is offered.
    run_groups(1, 1'b0, 20);
    a_val = grp(gk - 1);
    @(posedge clk); #1;
    bus.qin_en = 1'b0;
    bus.stuck  = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      bus.quad_in = grp(gk);
      bus.qin_en  = 1'b1;
      bus.stuck   = 1'b1;
      @(negedge clk);
      check("stall_busy", bus.busy, 1);
      check("stall_pout_en", bus.pout_en, 1);
      check("stall_hold_pixel", bus.pixel_out, a_val[23:16]);
    end
    run_groups(W - 1, 1'b0, 40);

    // Reset in the middle of the replayed bottom line.
    @(posedge clk); #1;
    bus.qin_en = 1'b0;
    bus.stuck  = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_pout_en", bus.pout_en, 0);
    check("post_rst_busy", bus.busy, 0);
    run_groups(2*W, 1'b1, 400);
    drain(200);
    check("sof_after_reset", sof_seen, 4);
    check("sb_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
